// File: rtl/enemy_group_if.sv
// rtl/enemy_group_if.sv - control, position, video and explosion signals of the enemy group
// master drives stimulus and observes the group; slave is the enemy_group block.
interface enemy_group_if #(
  parameter int N_ENEMY = 4
);
  localparam int KW   = $clog2(N_ENEMY + 1);
  localparam int SELW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

  logic                    start;
  logic [10*N_ENEMY-1:0]   set_x;
  logic [10*N_ENEMY-1:0]   set_y;
  logic [4*N_ENEMY-1:0]    enemy_blocked;
  logic [9:0]              b_x;
  logic [9:0]              b_y;
  logic [9:0]              v_x;
  logic [9:0]              v_y;
  logic                    explosion_scen;
  logic [9:0]              e_x;
  logic [9:0]              e_y;

  logic [10*N_ENEMY-1:0]   enemy_x;
  logic [10*N_ENEMY-1:0]   enemy_y;
  logic [N_ENEMY-1:0]      alive;
  logic                    death_signal;
  logic [KW-1:0]           kill_count;
  logic                    all_killed;
  logic                    enemy_on;
  logic [SELW-1:0]         enemy_sel;
  logic [3:0]              row;
  logic [3:0]              col;

  modport master (
    output start, set_x, set_y, enemy_blocked, b_x, b_y, v_x, v_y,
           explosion_scen, e_x, e_y,
    input  enemy_x, enemy_y, alive, death_signal, kill_count, all_killed,
           enemy_on, enemy_sel, row, col
  );

  modport slave (
    input  start, set_x, set_y, enemy_blocked, b_x, b_y, v_x, v_y,
           explosion_scen, e_x, e_y,
    output enemy_x, enemy_y, alive, death_signal, kill_count, all_killed,
           enemy_on, enemy_sel, row, col
  );
endinterface

// File: rtl/enemy_group.sv
// rtl/enemy_group.sv - N_ENEMY wandering enemies: tick-paced motion, explosion kills, bomberman contact, sprite lookup
// Optional macro ENEMY_CHASE_EN: a turning enemy first tries directions toward bomberman.
module enemy_group #(
  parameter int N_ENEMY    = 4,
  parameter int TICK_LIMIT = 300000,
  parameter int SPRITE_W   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  enemy_group_if.slave bus
);

  localparam int TW = (TICK_LIMIT > 0) ? $clog2(TICK_LIMIT + 1) : 1;
  localparam int KW = $clog2(N_ENEMY + 1);
  localparam int SELW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEFT  = 3'd1;
  localparam logic [2:0] ST_RIGHT = 3'd2;
  localparam logic [2:0] ST_UP    = 3'd3;
  localparam logic [2:0] ST_DOWN  = 3'd4;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [9:0] X_MIN = 10'd143;
  localparam logic [9:0] X_MAX = 10'(784 - SPRITE_W);
  localparam logic [9:0] Y_MIN = 10'd34;
  localparam logic [9:0] Y_MAX = 10'(516 - SPRITE_W);

  localparam logic signed [10:0] SPR_W  = 11'(SPRITE_W);
  localparam logic signed [10:0] SPR_M1 = 11'(SPRITE_W - 1);

  logic [N_ENEMY-1:0][9:0] pos_x;
  logic [N_ENEMY-1:0][9:0] pos_y;
  logic [N_ENEMY-1:0][2:0] state;
  logic [N_ENEMY-1:0]      alive_r;
  logic                    death_r;
  logic [KW-1:0]           kills_r;
  logic [TW-1:0]           tick;
  logic [15:0]             lfsr;
  logic                    running;

  logic                    step;
  logic                    lfsr_fb;
  logic [N_ENEMY-1:0][3:0] blk;
  logic [N_ENEMY-1:0][2:0] turn;
  logic [N_ENEMY-1:0]      cur_blk;
  logic [N_ENEMY-1:0]      kill;
  logic [N_ENEMY-1:0]      touch;
  logic [KW-1:0]           kill_n;
  logic signed [10:0]      sx, sy, cx, cy, bxs, bys, dxs, dys;
  logic [9:0]              pix_dx, pix_dy;

  // Returns {found, dir}: first unblocked direction scanning L,R,U,D from s.
  function automatic logic [2:0] scan_pick(input logic [3:0] b, input logic [1:0] s);
    logic [2:0] r;
    logic [1:0] d;
    r = 3'b000;
    for (int k = 0; k < 4; k++) begin
      d = s + 2'(k);
      if (!r[2] && !b[d]) r = {1'b1, d};
    end
    return r;
  endfunction

`ifdef ENEMY_CHASE_EN
  function automatic logic [2:0] chase_pick(input logic [3:0] b, input logic [1:0] s,
                                            input logic [9:0] ex, input logic [9:0] ey,
                                            input logic [9:0] bx, input logic [9:0] by);
    logic [9:0] adx, ady;
    logic [1:0] hd, vd, d1, d2;
    logic       hv, vv, v1, v2;
    adx = (bx > ex) ? bx - ex : ex - bx;
    ady = (by > ey) ? by - ey : ey - by;
    hd  = (bx > ex) ? DIR_RIGHT : DIR_LEFT;
    vd  = (by > ey) ? DIR_DOWN : DIR_UP;
    hv  = (bx != ex);
    vv  = (by != ey);
    if (adx >= ady) begin
      d1 = hd; v1 = hv; d2 = vd; v2 = vv;
    end else begin
      d1 = vd; v1 = vv; d2 = hd; v2 = hv;
    end
    if (v1 && !b[d1]) return {1'b1, d1};
    if (v2 && !b[d2]) return {1'b1, d2};
    return scan_pick(b, s);
  endfunction
`endif

  function automatic logic box_hit(input logic signed [10:0] x, input logic signed [10:0] y,
                                   input logic signed [10:0] x0, input logic signed [10:0] x1,
                                   input logic signed [10:0] y0, input logic signed [10:0] y1);
    return (x <= x1) && (x + SPR_M1 >= x0) && (y <= y1) && (y + SPR_M1 >= y0);
  endfunction

  function automatic logic signed [10:0] sabs(input logic signed [10:0] v);
    return (v < 0) ? -v : v;
  endfunction

  assign step    = (tick == TW'(TICK_LIMIT));
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    blk     = '0;
    turn    = '0;
    cur_blk = '0;
    kill    = '0;
    touch   = '0;
    kill_n  = '0;
    sx      = '0;
    sy      = '0;
    dxs     = '0;
    dys     = '0;
    cx      = signed'({1'b0, bus.e_x});
    cy      = signed'({1'b0, bus.e_y});
    bxs     = signed'({1'b0, bus.b_x});
    bys     = signed'({1'b0, bus.b_y});
    for (int i = 0; i < N_ENEMY; i++) begin
      sx = signed'({1'b0, pos_x[i]});
      sy = signed'({1'b0, pos_y[i]});
      blk[i] = bus.enemy_blocked[4*i +: 4] |
               {pos_y[i] == Y_MAX, pos_y[i] == Y_MIN, pos_x[i] == X_MAX, pos_x[i] == X_MIN};
      cur_blk[i] = blk[i][2'(state[i] - 3'd1)];
`ifdef ENEMY_CHASE_EN
      turn[i] = chase_pick(blk[i], lfsr[(2*i) % 16 +: 2], pos_x[i], pos_y[i], bus.b_x, bus.b_y);
`else
      turn[i] = scan_pick(blk[i], lfsr[(2*i) % 16 +: 2]);
`endif
      // Cross-shaped blast: horizontal and vertical arms, three tiles each way.
      kill[i] = bus.explosion_scen && alive_r[i] &&
                (box_hit(sx, sy, cx - 11'sd48, cx + 11'sd63, cy, cy + 11'sd15) ||
                 box_hit(sx, sy, cx, cx + 11'sd15, cy - 11'sd48, cy + 11'sd63));
      dxs = sx - bxs;
      dys = sy - bys;
      touch[i] = alive_r[i] && (sabs(dxs) < SPR_W) && (sabs(dys) < SPR_W);
      kill_n = kill_n + KW'(kill[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x   <= '0;
      pos_y   <= '0;
      state   <= '0;
      alive_r <= '0;
      death_r <= 1'b0;
      kills_r <= '0;
      tick    <= '0;
      lfsr    <= 16'hACE1;
      running <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      if (bus.start) begin
        pos_x   <= bus.set_x;
        pos_y   <= bus.set_y;
        alive_r <= '1;
        death_r <= 1'b0;
        kills_r <= '0;
        tick    <= '0;
        running <= 1'b1;
        for (int i = 0; i < N_ENEMY; i++) state[i] <= ST_LEFT;
      end else begin
        tick    <= step ? '0 : tick + TW'(1);
        alive_r <= alive_r & ~kill;
        kills_r <= kills_r + kill_n;
        if (|touch) death_r <= 1'b1;
        for (int i = 0; i < N_ENEMY; i++) begin
          if (step && alive_r[i] && !kill[i] && state[i] != ST_IDLE) begin
            if (!cur_blk[i]) begin
              case (state[i])
                ST_LEFT:  pos_x[i] <= pos_x[i] - 10'd1;
                ST_RIGHT: pos_x[i] <= pos_x[i] + 10'd1;
                ST_UP:    pos_y[i] <= pos_y[i] - 10'd1;
                ST_DOWN:  pos_y[i] <= pos_y[i] + 10'd1;
                default:  ;
              endcase
            end else if (turn[i][2]) begin
              state[i] <= {1'b0, turn[i][1:0]} + 3'd1;
            end
          end
        end
      end
    end
  end

  assign bus.enemy_x      = pos_x;
  assign bus.enemy_y      = pos_y;
  assign bus.alive        = alive_r;
  assign bus.death_signal = death_r;
  assign bus.kill_count   = kills_r;
  assign bus.all_killed   = running && (alive_r == '0);

  // Highest index is visited first so the lowest covering enemy wins.
  always_comb begin
    bus.enemy_on  = 1'b0;
    bus.enemy_sel = '0;
    bus.row       = '0;
    bus.col       = '0;
    pix_dx        = '0;
    pix_dy        = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      pix_dx = bus.v_x - pos_x[i];
      pix_dy = bus.v_y - pos_y[i];
      if (alive_r[i] && bus.v_x >= pos_x[i] && bus.v_y >= pos_y[i] &&
          pix_dx < 10'(SPRITE_W) && pix_dy < 10'(SPRITE_W)) begin
        bus.enemy_on  = 1'b1;
        bus.enemy_sel = SELW'(i);
        bus.row       = pix_dy[3:0];
        bus.col       = pix_dx[3:0];
      end
    end
  end

endmodule

// File: doc/enemy_group.md
ENEMY_GROUP -- requirements
Module: enemy_group

Interface
REQ-001 SHALL have parameter N_ENEMY, default 4, number of independently moving enemies (1..8).
REQ-002 SHALL have parameter TICK_LIMIT, default 300000, clk cycles per 1-pixel move step.
REQ-003 SHALL have parameter SPRITE_W, default 16, square enemy and bomberman sprite size in pixels.
REQ-004 SHALL have ports: clk input 1 system clock; reset_n input 1; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have ports: start input 1 (load and launch pulse); set_x, set_y input 10*N_ENEMY (packed start positions, enemy i at [10i+9:10i]).
REQ-006 SHALL have port enemy_blocked input 4*N_ENEMY, enemy i bits [4i+3:4i] = {down, up, right, left}.
REQ-007 SHALL have ports: b_x, b_y input 10 (bomberman top-left); v_x, v_y input 10 (current VGA pixel).
REQ-008 SHALL have ports: explosion_scen input 1 (1-cycle explosion strobe); e_x, e_y input 10 (explosion centre tile top-left).
REQ-009 SHALL have outputs: enemy_x, enemy_y 10*N_ENEMY packed positions; alive N_ENEMY mask; death_signal 1; kill_count $clog2(N_ENEMY+1); all_killed 1.
REQ-010 SHALL have outputs: enemy_on 1; enemy_sel $clog2(N_ENEMY) index of the enemy drawn; row, col 4 bits sprite-relative pixel for the sprite ROM.

Function
REQ-011 Each enemy SHALL have a state in {IDLE, LEFT, RIGHT, UP, DOWN}; all enter LEFT on start.
REQ-012 A shared tick counter SHALL count 0..TICK_LIMIT, wrapping to 0; move steps occur only in the cycle where count == TICK_LIMIT.
REQ-013 On a step, an alive enemy SHALL move 1 pixel in its direction unless that direction is blocked: blocked bit set, or at wall (x==143 left, x==784-SPRITE_W right, y==34 up, y==516-SPRITE_W down).
REQ-014 When the current direction is blocked, the enemy SHALL turn (no move that step) to an unblocked direction chosen by the selector (REQ-015/REQ-028), scanning LEFT,RIGHT,UP,DOWN cyclically from the start index; if all four are blocked it SHALL stay in its state without moving.
REQ-015 Selector start index SHALL be lfsr[2i+1:2i] for enemy i (wrapping mod 16); lfsr is 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advanced every clk cycle, never zero.
REQ-016 On explosion_scen, an alive enemy SHALL die if its sprite box overlaps (inclusive) the horizontal arm [e_x-48, e_x+63] x [e_y, e_y+15] or the vertical arm [e_x, e_x+15] x [e_y-48, e_y+63]; arithmetic in 11-bit signed, with no wrap at screen edges.
REQ-017 A dead enemy SHALL freeze its position, never move, never draw, and never cause death.
REQ-018 kill_count SHALL increase by the number of enemies killed in that cycle (simultaneous kills all counted); all_killed = (alive == 0) while not in IDLE.
REQ-019 death_signal SHALL set (sticky) when any enemy alive at the start of the cycle overlaps the bomberman box: |ex-bx| < SPRITE_W and |ey-by| < SPRITE_W; a kill in the same cycle does not suppress it.
REQ-020 enemy_on SHALL be combinational: 1 when any alive enemy box contains (v_x, v_y); enemy_sel = the lowest such index; row = v_y-enemy_y[sel], col = v_x-enemy_x[sel], low 4 bits.
REQ-021 start SHALL load positions from set_x/set_y, set alive to all-ones, clear kill_count, death_signal and the tick counter, and override a coincident explosion or step.

Reset
REQ-022 While reset_n=0, positions SHALL be 0, states IDLE, alive 0, death_signal 0, kill_count 0, tick counter 0, lfsr 16'hACE1.
REQ-023 Reset asserted mid-move or mid-explosion SHALL take effect immediately; no output glitches remain after release.
REQ-024 After reset, enemies SHALL remain in IDLE (no motion, enemy_on 0) until start.

Configuration
REQ-025 Macro ENEMY_CHASE_EN SHALL select the turn policy.
REQ-026 With ENEMY_CHASE_EN defined, the turning enemy SHALL first try the axis of larger |b-e| distance toward bomberman, then the other toward-axis, then fall back to the REQ-015 scan.
REQ-027 Without ENEMY_CHASE_EN, turning SHALL use only the REQ-015 LFSR scan.
REQ-028 Both builds SHALL have identical ports and timing.

Verification
REQ-029 TICK_LIMIT=3, start with enemy0 at (200,100), no blocks -> x decrements 1 every 4 cycles until 143, then turns.
REQ-030 enemy0 at (143,34), left and up at walls, right blocked -> next state DOWN, position unchanged that step.
REQ-031 Explosion at (300,200), enemy1 at (252,205), enemy2 at (300,250) -> both die in the same cycle, kill_count +2, alive bits cleared.
REQ-032 Bomberman at (210,100), enemy at (200,100) -> death_signal=1 next cycle and stays 1; dead enemy at same spot -> stays 0.
REQ-033 Two alive enemies covering pixel (205,105) -> enemy_on=1, enemy_sel=lower index, row/col relative to it.
REQ-034 reset_n low during motion -> all outputs at reset values asynchronously; ENEMY_CHASE_EN build with bomberman far right -> blocked enemy turns RIGHT.
